// File: rtl/gpio_hex_pkg.sv
// Shared types and header layout for the GPIO hex transmitter.
// The four digit fields sit byte-aligned on the header; the top bit of each byte is never driven.
package gpio_hex_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int         DIGITS  = 4;
  localparam int         SEG_W   = 7;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [3:0][4:0] DIG_LSB = {5'd24, 5'd16, 5'd8, 5'd0};
  localparam logic [3:0][4:0] DIG_PAD = {5'd31, 5'd23, 5'd15, 5'd7};

endpackage

// File: rtl/gpio_hex_out_if.sv
// Board-side controls and status of the hex transmitter: pushbuttons, switches and LEDs.
interface gpio_hex_out_if;
  logic [3:1] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  modport slave  (input KEY, input SW, output LEDR);
  modport master (output KEY, output SW, input LEDR);
endinterface

// File: rtl/gpio_hex_out_hex7seg.sv
// Combinational nibble to active-low 7-segment decoder, bit0 = a ... bit6 = g.
module hex7seg (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    unique case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/gpio_hex_out.sv
// Hex counter driven onto the 40-pin header as four active-low 7-segment digits.
// state | meaning:  HOLD | count frozen, prescaler parked at 0;  RUN | count steps every TICK_DIV cycles
module gpio_hex_out
  import gpio_hex_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  gpio_hex_out_if.slave brd,
  inout  wire  [31:0]   GPIO
);

  localparam int               PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [3:1]       key_s1_q, key_s2_q, key_s3_q;
  logic [1:0]       sw_s1_q, sw_s2_q;
  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [3:0][6:0]  pat_q;
  logic [3:0][6:0]  seg;
  logic [3:1]       press;
  logic             tick;
  logic             oe;
  logic             dir_down;

  assign press    = key_s3_q & ~key_s2_q;
  assign oe       = sw_s2_q[0];
  assign dir_down = sw_s2_q[1];

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    tick    = 1'b0;
    cnt_d   = cnt_q;

    if (press[1]) state_d = (state_q == HOLD) ? RUN : HOLD;

    if (state_q == RUN) begin
      tick = (pre_q == PRE_MAX);
      if (!press[1] && !tick) pre_d = pre_q + 1'b1;
    end

    // Clear beats load beats tick; a dropped tick still restarts the prescaler.
    if (press[3])      cnt_d = '0;
    else if (press[2]) cnt_d = {8'h00, brd.SW[7:0]};
    else if (tick)     cnt_d = dir_down ? cnt_q - 16'd1 : cnt_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1_q <= '1;
      key_s2_q <= '1;
      key_s3_q <= '1;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      state_q  <= HOLD;
      pre_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= {DIGITS{SEG_OFF}};
    end else begin
      key_s1_q <= brd.KEY;
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
      sw_s1_q  <= brd.SW[9:8];
      sw_s2_q  <= sw_s1_q;
      state_q  <= state_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      pat_q    <= seg;
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    hex7seg u_seg (
      .nib_i (cnt_q[d*4 +: 4]),
      .seg_o (seg[d])
    );
    for (genvar s = 0; s < SEG_W; s++) begin : g_bit
      assign GPIO[DIG_LSB[d] + s] = oe ? pat_q[d][s] : 1'bz;
    end
    assign GPIO[DIG_PAD[d]] = 1'bz;
  end

  assign brd.LEDR = {8'h00, oe, state_q == RUN};

endmodule

// File: tb/tb_gpio_hex_out.sv
// Bench for gpio_hex_out: event-scheduled reference model plus directed and table-driven checks.
module tb_gpio_hex_out;
  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wire  [31:0] gpio;

  gpio_hex_out_if brd ();

  gpio_hex_out #(.TICK_DIV(TICK)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .brd      (brd),
    .GPIO     (gpio)
  );

  // Undriven pins read back as 0, so "Z" shows up as 0 and "off" segments as 1.
  for (genvar i = 0; i < 32; i++) begin : g_pd
    pulldown (gpio[i]);
  end

  always #5 clk = ~clk;

  logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_gpio(input int val, input bit off, input bit oe);
    logic [31:0] r;
    r = '0;
    if (oe) begin
      for (int d = 0; d < 4; d++) begin
        logic [6:0] s;
        s = off ? 7'h7F : SEG_TBL[(val >> (4*d)) & 15];
        r[8*d +: 7] = s;
      end
    end
    return r;
  endfunction

  // Reference model: key presses are scheduled as events at the cycle they take effect.
  int cyc     = 0;
  bit ev_tg  [int];
  bit ev_clr [int];
  int ev_ld  [int];
  int m_cnt   = 0;
  bit m_run   = 0;
  int m_start = 0;
  int m_shown = 0;
  bit m_off   = 1;
  bit m_tick;
  bit oe_cfg  = 0;
  bit chk_en  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_run = 0; m_start = 0; m_shown = 0; m_off = 1;
    end else begin
      cyc++;
      m_shown = m_cnt;
      m_off   = 0;
      m_tick  = m_run && (((cyc - m_start) % TICK) == 0);
      if (ev_clr.exists(cyc))     m_cnt = 0;
      else if (ev_ld.exists(cyc)) m_cnt = ev_ld[cyc];
      else if (m_tick)            m_cnt = brd.SW[9] ? ((m_cnt - 1) & 16'hFFFF) : ((m_cnt + 1) & 16'hFFFF);
      if (ev_tg.exists(cyc)) begin
        m_run   = !m_run;
        m_start = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gpio_model", gpio, exp_gpio(m_shown, m_off, oe_cfg));
      check("ledr_model", {22'h0, brd.LEDR}, {22'h0, 8'h00, oe_cfg, m_run});
    end
  end

  // A falling key is seen by the design's edge detector three edges later.
  task automatic press(input logic [3:1] mask, input int hold, input logic [7:0] sw_val);
    int e;
    brd.SW[7:0] = sw_val;
    e = cyc + 3;
    if (mask[1]) ev_tg[e]  = 1'b1;
    if (mask[3]) ev_clr[e] = 1'b1;
    if (mask[2]) ev_ld[e]  = int'(sw_val);
    brd.KEY = ~mask;
    repeat (hold) @(negedge clk);
    brd.KEY = 3'b111;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  typedef struct {
    logic [7:0]  sw;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int c;
    int e;
    int guard;

    vecs[0] = '{8'h00, 32'h40404040};
    vecs[1] = '{8'hFF, 32'h40400E0E};
    vecs[2] = '{8'h12, 32'h40407924};
    vecs[3] = '{8'hA5, 32'h40400812};
    vecs[4] = '{8'h3C, 32'h40403046};
    vecs[5] = '{8'h7B, 32'h40407803};
    vecs[6] = '{8'hD9, 32'h40402110};
    vecs[7] = '{8'h6E, 32'h40400206};
    vecs[8] = '{8'h48, 32'h40401900};

    brd.KEY = 3'b111;
    brd.SW  = '0;
    repeat (3) @(negedge clk);
    check("rst_gpio_z", gpio, 32'h0);
    check("rst_ledr", {22'h0, brd.LEDR}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("hold_oe0_gpio_z", gpio, 32'h0);

    // Output enable brings up all four "0" digits
    brd.SW[8] = 1'b1;
    repeat (3) @(negedge clk);
    check("oe_on_zeros", gpio, 32'h40404040);
    check("oe_on_ledr", {22'h0, brd.LEDR}, 32'h002);
    oe_cfg = 1'b1;
    chk_en = 1'b1;

    // First step exactly TICK cycles after the toggle takes effect
    c = cyc;
    press(3'b001, 1, 8'h00);
    wait_to(c + 7);
    check("step_not_yet", gpio, 32'h40404040);
    wait_to(c + 8);
    check("first_step", gpio, 32'h40404079);
    check("run_ledr", {22'h0, brd.LEDR}, 32'h003);
    wait_to(c + 68);
    check("step16_0010", gpio, 32'h40407940);

    // Load 00FF, count down through 0000 to FFFF
    press(3'b001, 1, 8'h00);
    brd.SW[9] = 1'b1;
    repeat (3) @(negedge clk);
    press(3'b010, 1, 8'hFF);
    check("load_ff", gpio, 32'h40400E0E);
    c = cyc;
    press(3'b001, 1, 8'hFF);
    wait_to(c + 1027);
    check("down_zero", gpio, 32'h40404040);
    wait_to(c + 1028);
    check("wrap_ffff", gpio, 32'h0E0E0E0E);

    // Clear and load together on a tick cycle: clear wins, tick dropped
    guard = 0;
    while ((((cyc + 3 - m_start) % TICK) != 0) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    e = cyc + 3;
    press(3'b110, 1, 8'h5A);
    wait_to(e + 1);
    check("clr_wins", gpio, 32'h40404040);
    wait_to(e + 4);
    check("no_step_yet", gpio, 32'h40404040);
    wait_to(e + 5);
    check("step_after_clr", gpio, 32'h0E0E0E0E);

    // Long hold toggles once; then back to RUN and to HOLD, frozen 50 cycles
    press(3'b001, 20, 8'h00);
    check("long_hold_one_toggle", {22'h0, brd.LEDR}, 32'h002);
    press(3'b001, 1, 8'h00);
    check("rerun_ledr", {22'h0, brd.LEDR}, 32'h003);
    press(3'b001, 1, 8'h00);
    c = m_cnt;
    repeat (50) @(negedge clk);
    check("hold_frozen", gpio, exp_gpio(c, 1'b0, 1'b1));

    // Segment table via loads in HOLD
    for (int i = 0; i < 9; i++) begin
      press(3'b010, 1, vecs[i].sw);
      check("vec_load", gpio, vecs[i].exp);
    end

    // Randomised controls against the model
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0: press(3'b001, $urandom_range(1, 6), 8'($urandom));
        1: press(3'b010, $urandom_range(1, 6), 8'($urandom));
        2: press(3'b100, $urandom_range(1, 6), 8'($urandom));
        3: press(3'b110, $urandom_range(1, 6), 8'($urandom));
        4: if (!m_run) begin
             brd.SW[9] = 1'($urandom_range(0, 1));
             repeat (3) @(negedge clk);
           end
        default: repeat ($urandom_range(1, 40)) @(negedge clk);
      endcase
    end

    // Reset in the middle of RUN at count 1234
    if (m_run) press(3'b001, 1, 8'h00);
    brd.SW[9] = 1'b0;
    repeat (3) @(negedge clk);
    press(3'b100, 1, 8'h00);
    press(3'b001, 1, 8'h00);
    guard = 0;
    while (m_cnt != 16'h1234 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_1234_in_time", {31'h0, guard < 20000}, 32'h1);
    @(negedge clk);
    check("pre_rst_1234", gpio, 32'h79243019);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_async_z", gpio, 32'h0);
    check("rst_async_ledr", {22'h0, brd.LEDR}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_zero", gpio, 32'h40404040);
    check("post_rst_ledr", {22'h0, brd.LEDR}, 32'h002);
    chk_en = 1'b1;
    c = cyc;
    press(3'b001, 1, 8'h00);
    wait_to(c + 7);
    check("post_rst_not_yet", gpio, 32'h40404040);
    wait_to(c + 8);
    check("post_rst_first_step", gpio, 32'h40404079);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule
